// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and store lane helpers for the MEM/EX load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic load_legal(input logic [2:0] f3);
    load_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_legal(input logic [2:0] f3);
    store_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: is_misaligned = off[0];
      F3_W:        is_misaligned = (off != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Half stores only look at off[1], so a misaligned half is silently masked.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_be = 4'b0001 << off;
      F3_H:    store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    store_wdata = {4{d[7:0]}};
      F3_H:    store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension of the bus read word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (offset)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{w_byte[7]}}, w_byte};
      F3_H:    result = {{16{w_half[15]}}, w_half};
      F3_BU:   result = {24'd0, w_byte};
      F3_HU:   result = {16'd0, w_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memex_lsu.sv
// MEM/EX load/store unit: latches one access, runs req/ack on the data bus, stalls upstream.
// Optional MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of masking the address.
module memex_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        invalid_MEMEX,
  input  logic        mem_read_MEMEX,
  input  logic        mem_write_MEMEX,
  input  logic [2:0]  funct3_MEMEX,
  input  logic [31:0] alu_result_MEMEX,
  input  logic [31:0] store_data_MEMEX,
  input  logic [3:0]  rd_MEMEX,
  input  logic        regfile_we_MEMEX,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        stall_MEMEX,
  output logic [3:0]  rd_out,
  output logic [31:0] result_out,
  output logic        regfile_we_out,
  output logic        misaligned_MEMEX
);

  lsu_state_t  r_state;
  lsu_state_t  w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_result;
  logic [3:0]  r_be;
  logic [3:0]  r_rd;
  logic        r_bus_we;
  logic        r_rf_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;

  logic        w_mem_op;
  logic        w_legal;
  logic        w_misaligned;
  logic        w_start;
  logic [31:0] w_load_data;

  assign w_mem_op = mem_read_MEMEX | mem_write_MEMEX;
  assign w_legal  = (mem_read_MEMEX ^ mem_write_MEMEX) &
                    (mem_read_MEMEX ? load_legal(funct3_MEMEX) : store_legal(funct3_MEMEX));

`ifdef MISALIGN_TRAP_EN
  assign w_misaligned     = is_misaligned(funct3_MEMEX, alu_result_MEMEX[1:0]);
  assign misaligned_MEMEX = rst_n & (r_state == IDLE) & ~invalid_MEMEX &
                            w_mem_op & w_legal & w_misaligned;
`else
  assign w_misaligned     = 1'b0;
  assign misaligned_MEMEX = 1'b0;
`endif

  assign w_start = (r_state == IDLE) & ~invalid_MEMEX & w_mem_op & w_legal & ~w_misaligned;

  lsu_load_align u_align (
    .rdata  (dbus_rdata),
    .offset (r_offset),
    .funct3 (r_funct3),
    .result (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_be     <= '0;
      r_rd     <= '0;
      r_bus_we <= 1'b0;
      r_rf_we  <= 1'b0;
      r_funct3 <= '0;
      r_offset <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_addr   <= {alu_result_MEMEX[31:2], 2'b00};
        r_bus_we <= mem_write_MEMEX;
        r_be     <= mem_write_MEMEX ? store_be(funct3_MEMEX, alu_result_MEMEX[1:0]) : 4'b0000;
        r_wdata  <= mem_write_MEMEX ? store_wdata(funct3_MEMEX, store_data_MEMEX) : 32'd0;
        r_funct3 <= funct3_MEMEX;
        r_offset <= alu_result_MEMEX[1:0];
        r_rd     <= rd_MEMEX;
        r_rf_we  <= regfile_we_MEMEX & mem_read_MEMEX;
      end
      if ((r_state == WAIT) && dbus_ack) begin
        r_result <= r_bus_we ? 32'd0 : w_load_data;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = WAIT;
      WAIT:    if (dbus_ack) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The WB register keeps advancing while we stall, so writeback is masked until DONE.
  always_comb begin
    stall_MEMEX    = 1'b0;
    rd_out         = rd_MEMEX;
    result_out     = alu_result_MEMEX;
    regfile_we_out = regfile_we_MEMEX & ~invalid_MEMEX;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          stall_MEMEX    = 1'b1;
          regfile_we_out = 1'b0;
        end else if (~invalid_MEMEX & w_mem_op & ~w_legal) begin
          result_out     = 32'd0;
          regfile_we_out = 1'b0;
        end else if (~invalid_MEMEX & w_mem_op & w_misaligned) begin
          regfile_we_out = 1'b0;
        end
      end
      WAIT: begin
        stall_MEMEX    = 1'b1;
        regfile_we_out = 1'b0;
      end
      DONE: begin
        rd_out         = r_rd;
        result_out     = r_result;
        regfile_we_out = r_rf_we;
      end
      default: begin
        regfile_we_out = 1'b0;
      end
    endcase
  end

  assign dbus_req   = (r_state == WAIT);
  assign dbus_we    = r_bus_we;
  assign dbus_addr  = r_addr;
  assign dbus_be    = r_be;
  assign dbus_wdata = r_wdata;

endmodule

// File: tb/tb_memex_lsu.sv
// Directed bench for memex_lsu: loads, stores, passthrough, illegal/invalid ops and reset in WAIT.
module tb_memex_lsu;

  logic        clk;
  logic        rst_n;
  logic        invalid_MEMEX;
  logic        mem_read_MEMEX;
  logic        mem_write_MEMEX;
  logic [2:0]  funct3_MEMEX;
  logic [31:0] alu_result_MEMEX;
  logic [31:0] store_data_MEMEX;
  logic [3:0]  rd_MEMEX;
  logic        regfile_we_MEMEX;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        stall_MEMEX;
  logic [3:0]  rd_out;
  logic [31:0] result_out;
  logic        regfile_we_out;
  logic        misaligned_MEMEX;

  int n_checks = 0;
  int n_fail   = 0;

  memex_lsu dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .invalid_MEMEX    (invalid_MEMEX),
    .mem_read_MEMEX   (mem_read_MEMEX),
    .mem_write_MEMEX  (mem_write_MEMEX),
    .funct3_MEMEX     (funct3_MEMEX),
    .alu_result_MEMEX (alu_result_MEMEX),
    .store_data_MEMEX (store_data_MEMEX),
    .rd_MEMEX         (rd_MEMEX),
    .regfile_we_MEMEX (regfile_we_MEMEX),
    .dbus_req         (dbus_req),
    .dbus_we          (dbus_we),
    .dbus_addr        (dbus_addr),
    .dbus_be          (dbus_be),
    .dbus_wdata       (dbus_wdata),
    .dbus_ack         (dbus_ack),
    .dbus_rdata       (dbus_rdata),
    .stall_MEMEX      (stall_MEMEX),
    .rd_out           (rd_out),
    .result_out       (result_out),
    .regfile_we_out   (regfile_we_out),
    .misaligned_MEMEX (misaligned_MEMEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    invalid_MEMEX    = 1'b0;
    mem_read_MEMEX   = 1'b0;
    mem_write_MEMEX  = 1'b0;
    funct3_MEMEX     = 3'b000;
    alu_result_MEMEX = 32'd0;
    store_data_MEMEX = 32'd0;
    rd_MEMEX         = 4'd0;
    regfile_we_MEMEX = 1'b0;
    dbus_ack         = 1'b0;
    dbus_rdata       = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    alu_result_MEMEX = 32'h77;
    rd_MEMEX         = 4'd3;
    regfile_we_MEMEX = 1'b1;
    tick();
    tick();
    n_checks++;
    if (dbus_req !== 1'b0 || dbus_we !== 1'b0 || dbus_be !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_bus_ctl: got req=%b we=%b be=%h want 0 0 0", dbus_req, dbus_we, dbus_be);
    end
    n_checks++;
    if (dbus_addr !== 32'd0 || dbus_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus_data: got addr=%h wdata=%h want 0 0", dbus_addr, dbus_wdata);
    end
    n_checks++;
    if (misaligned_MEMEX !== 1'b0 || stall_MEMEX !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got mis=%b stall=%b want 0 0", misaligned_MEMEX, stall_MEMEX);
    end
    n_checks++;
    if (result_out !== 32'h77 || rd_out !== 4'd3 || regfile_we_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_passthru: got res=%h rd=%0d we=%b want 77 3 1", result_out, rd_out, regfile_we_out);
    end
    rst_n = 1'b1;
    set_idle();
    tick();
  endtask

  task automatic test_lb_zero_wait();
    mem_read_MEMEX   = 1'b1;
    funct3_MEMEX     = 3'b000;
    alu_result_MEMEX = 32'h103;
    rd_MEMEX         = 4'd5;
    regfile_we_MEMEX = 1'b1;
    #1;
    n_checks++;
    if (stall_MEMEX !== 1'b1 || dbus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_idle: got stall=%b req=%b want 1 0", stall_MEMEX, dbus_req);
    end
    tick();
    n_checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 32'h100 || dbus_be !== 4'h0 || dbus_we !== 1'b0 || stall_MEMEX !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_wait: got req=%b addr=%h be=%h we=%b stall=%b want 1 100 0 0 1",
               dbus_req, dbus_addr, dbus_be, dbus_we, stall_MEMEX);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h80AABBCC;
    tick();
    dbus_ack = 1'b0;
    #1;
    n_checks++;
    if (stall_MEMEX !== 1'b0 || dbus_req !== 1'b0 || result_out !== 32'hFFFFFF80 ||
        rd_out !== 4'd5 || regfile_we_out !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_done: got stall=%b req=%b res=%h rd=%0d we=%b want 0 0 ffffff80 5 1",
               stall_MEMEX, dbus_req, result_out, rd_out, regfile_we_out);
    end
    set_idle();
    tick();
  endtask

  task automatic test_sh_waits();
    int stall_cnt;
    int req_cnt;
    mem_write_MEMEX  = 1'b1;
    funct3_MEMEX     = 3'b001;
    alu_result_MEMEX = 32'h202;
    store_data_MEMEX = 32'h1234ABCD;
    #1;
    stall_cnt = stall_MEMEX ? 1 : 0;
    req_cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      dbus_ack = 1'b0;
      #1;
      if (!stall_MEMEX) break;
      stall_cnt++;
      if (dbus_req) req_cnt++;
      n_checks++;
      if (dbus_req !== 1'b1 || dbus_addr !== 32'h200 || dbus_be !== 4'b1100 ||
          dbus_wdata !== 32'hABCDABCD || dbus_we !== 1'b1) begin
        n_fail++;
        $display("FAIL sh_wait%0d: got req=%b addr=%h be=%b wdata=%h we=%b want 1 200 1100 abcdabcd 1",
                 i, dbus_req, dbus_addr, dbus_be, dbus_wdata, dbus_we);
      end
      alu_result_MEMEX = 32'hDEAD0000 + i;
      store_data_MEMEX = 32'h0;
      funct3_MEMEX     = 3'b010;
      if (i == 3) dbus_ack = 1'b1;
    end
    n_checks++;
    if (stall_cnt !== 5 || req_cnt !== 4) begin
      n_fail++;
      $display("FAIL sh_counts: got stall_cycles=%0d req_cycles=%0d want 5 4", stall_cnt, req_cnt);
    end
    n_checks++;
    if (regfile_we_out !== 1'b0 || result_out !== 32'd0) begin
      n_fail++;
      $display("FAIL sh_done: got we=%b res=%h want 0 0", regfile_we_out, result_out);
    end
    set_idle();
    tick();
  endtask

  task automatic test_lhu_then_alu();
    mem_read_MEMEX   = 1'b1;
    funct3_MEMEX     = 3'b101;
    alu_result_MEMEX = 32'h10;
    rd_MEMEX         = 4'd7;
    regfile_we_MEMEX = 1'b1;
    tick();
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h0000F00F;
    tick();
    dbus_ack = 1'b0;
    #1;
    n_checks++;
    if (result_out !== 32'h0000F00F || rd_out !== 4'd7 || regfile_we_out !== 1'b1) begin
      n_fail++;
      $display("FAIL lhu_done: got res=%h rd=%0d we=%b want 0000f00f 7 1", result_out, rd_out, regfile_we_out);
    end
    set_idle();
    alu_result_MEMEX = 32'h55;
    rd_MEMEX         = 4'd8;
    regfile_we_MEMEX = 1'b1;
    tick();
    n_checks++;
    if (result_out !== 32'h55 || stall_MEMEX !== 1'b0 || rd_out !== 4'd8 || regfile_we_out !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_pass: got res=%h stall=%b rd=%0d we=%b want 55 0 8 1",
               result_out, stall_MEMEX, rd_out, regfile_we_out);
    end
    set_idle();
    tick();
  endtask

  task automatic test_invalid();
    invalid_MEMEX    = 1'b1;
    mem_read_MEMEX   = 1'b1;
    funct3_MEMEX     = 3'b010;
    alu_result_MEMEX = 32'h40;
    rd_MEMEX         = 4'd2;
    regfile_we_MEMEX = 1'b1;
    dbus_ack         = 1'b1;
    #1;
    n_checks++;
    if (stall_MEMEX !== 1'b0 || regfile_we_out !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_idle: got stall=%b we=%b want 0 0", stall_MEMEX, regfile_we_out);
    end
    tick();
    n_checks++;
    if (dbus_req !== 1'b0 || stall_MEMEX !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_noreq: got req=%b stall=%b want 0 0", dbus_req, stall_MEMEX);
    end
    set_idle();
    tick();
  endtask

  task automatic test_illegal();
    mem_read_MEMEX   = 1'b1;
    funct3_MEMEX     = 3'b011;
    alu_result_MEMEX = 32'h33;
    regfile_we_MEMEX = 1'b1;
    rd_MEMEX         = 4'd6;
    #1;
    n_checks++;
    if (stall_MEMEX !== 1'b0 || result_out !== 32'd0 || regfile_we_out !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_load: got stall=%b res=%h we=%b want 0 0 0", stall_MEMEX, result_out, regfile_we_out);
    end
    mem_read_MEMEX   = 1'b0;
    mem_write_MEMEX  = 1'b1;
    funct3_MEMEX     = 3'b100;
    regfile_we_MEMEX = 1'b0;
    tick();
    n_checks++;
    if (dbus_req !== 1'b0 || stall_MEMEX !== 1'b0 || result_out !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_store: got req=%b stall=%b res=%h want 0 0 0", dbus_req, stall_MEMEX, result_out);
    end
    set_idle();
    tick();
  endtask

  task automatic test_misalign();
    mem_read_MEMEX   = 1'b1;
    funct3_MEMEX     = 3'b010;
    alu_result_MEMEX = 32'h06;
    rd_MEMEX         = 4'd1;
    regfile_we_MEMEX = 1'b1;
    #1;
`ifdef MISALIGN_TRAP_EN
    n_checks++;
    if (misaligned_MEMEX !== 1'b1 || stall_MEMEX !== 1'b0 || regfile_we_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_trap: got mis=%b stall=%b we=%b want 1 0 0", misaligned_MEMEX, stall_MEMEX, regfile_we_out);
    end
    tick();
    set_idle();
    #1;
    n_checks++;
    if (dbus_req !== 1'b0 || misaligned_MEMEX !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_noreq: got req=%b mis=%b want 0 0", dbus_req, misaligned_MEMEX);
    end
`else
    n_checks++;
    if (misaligned_MEMEX !== 1'b0 || stall_MEMEX !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_mask_idle: got mis=%b stall=%b want 0 1", misaligned_MEMEX, stall_MEMEX);
    end
    tick();
    n_checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 32'h04) begin
      n_fail++;
      $display("FAIL mis_mask_addr: got req=%b addr=%h want 1 4", dbus_req, dbus_addr);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h11223344;
    tick();
    dbus_ack = 1'b0;
    #1;
    n_checks++;
    if (result_out !== 32'h11223344 || regfile_we_out !== 1'b1 || rd_out !== 4'd1) begin
      n_fail++;
      $display("FAIL mis_mask_done: got res=%h we=%b rd=%0d want 11223344 1 1", result_out, regfile_we_out, rd_out);
    end
    set_idle();
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    mem_write_MEMEX  = 1'b1;
    funct3_MEMEX     = 3'b010;
    alu_result_MEMEX = 32'h08;
    store_data_MEMEX = 32'hCAFEF00D;
    tick();
    n_checks++;
    if (dbus_req !== 1'b1 || dbus_be !== 4'hF || dbus_wdata !== 32'hCAFEF00D || dbus_we !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_sw: got req=%b be=%h wdata=%h we=%b want 1 f cafef00d 1", dbus_req, dbus_be, dbus_wdata, dbus_we);
    end
    dbus_ack = 1'b1;
    tick();
    set_idle();
    mem_read_MEMEX   = 1'b1;
    funct3_MEMEX     = 3'b100;
    alu_result_MEMEX = 32'h09;
    rd_MEMEX         = 4'd4;
    regfile_we_MEMEX = 1'b1;
    tick();
    n_checks++;
    if (stall_MEMEX !== 1'b1 || dbus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got stall=%b req=%b want 1 0", stall_MEMEX, dbus_req);
    end
    tick();
    n_checks++;
    if (dbus_addr !== 32'h08 || dbus_be !== 4'h0 || dbus_we !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_lbu_bus: got addr=%h be=%h we=%b want 8 0 0", dbus_addr, dbus_be, dbus_we);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h0000A500;
    tick();
    dbus_ack = 1'b0;
    #1;
    n_checks++;
    if (result_out !== 32'h000000A5 || rd_out !== 4'd4 || regfile_we_out !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_lbu_done: got res=%h rd=%0d we=%b want a5 4 1", result_out, rd_out, regfile_we_out);
    end
    set_idle();
    tick();
  endtask

  task automatic test_reset_in_wait();
    mem_write_MEMEX  = 1'b1;
    funct3_MEMEX     = 3'b000;
    alu_result_MEMEX = 32'h21;
    store_data_MEMEX = 32'h000000EE;
    tick();
    n_checks++;
    if (dbus_req !== 1'b1 || dbus_be !== 4'b0010 || dbus_wdata !== 32'hEEEEEEEE) begin
      n_fail++;
      $display("FAIL rst_sb_bus: got req=%b be=%b wdata=%h want 1 0010 eeeeeeee", dbus_req, dbus_be, dbus_wdata);
    end
    rst_n = 1'b0;
    set_idle();
    tick();
    n_checks++;
    if (dbus_req !== 1'b0 || stall_MEMEX !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_drop: got req=%b stall=%b want 0 0", dbus_req, stall_MEMEX);
    end
    rst_n            = 1'b1;
    alu_result_MEMEX = 32'h99;
    rd_MEMEX         = 4'd9;
    dbus_ack         = 1'b1;
    dbus_rdata       = 32'h12345678;
    tick();
    dbus_ack = 1'b0;
    #1;
    n_checks++;
    if (dbus_req !== 1'b0 || result_out !== 32'h99 || rd_out !== 4'd9 || regfile_we_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray_ack: got req=%b res=%h rd=%0d we=%b want 0 99 9 0",
               dbus_req, result_out, rd_out, regfile_we_out);
    end
    set_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_lb_zero_wait();
    test_sh_waits();
    test_lhu_then_alu();
    test_invalid();
    test_illegal();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memex_lsu.md
# memex_lsu

Load/store unit of the combined MEM/EX stage of the RV32E pipeline. It sits directly upstream of the MEMEX/WB pipeline register and feeds its `rd`, result and write-enable inputs. It executes byte, half and word loads and stores over a single-master data bus with a req/ack handshake, stalling the front of the pipeline while an access is outstanding. Non-memory instructions pass their ALU result through unchanged with no added latency.

## Interface
- No parameters. Data width is 32 bits and the register index is 4 bits (16 registers, RV32E), both fixed.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `invalid_MEMEX` in 1: the current instruction is a bubble; no bus access and no stall.
- `mem_read_MEMEX`, `mem_write_MEMEX` in 1 each: load / store. Both high together is illegal.
- `funct3_MEMEX` in 3: access size and signedness.
- `alu_result_MEMEX` in 32: effective address for memory ops, result for all other ops.
- `store_data_MEMEX` in 32: rs2 value.
- `rd_MEMEX` in 4, `regfile_we_MEMEX` in 1: destination register and its write enable from decode.
- `dbus_req` out 1, `dbus_we` out 1, `dbus_addr` out 32 (word-aligned, bits [1:0] = 0), `dbus_be` out 4, `dbus_wdata` out 32: bus request.
- `dbus_ack` in 1, `dbus_rdata` in 32: bus response.
- `stall_MEMEX` out 1: freezes PC and the upstream pipeline registers.
- `rd_out` out 4, `result_out` out 32, `regfile_we_out` out 1: connect to the MEMEX/WB register.
- `misaligned_MEMEX` out 1: misaligned-access flag.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, with `invalid_MEMEX`=0 and a legal, aligned memory op:
  - assert `stall_MEMEX`;
  - latch addr, we, be, wdata, funct3, addr[1:0], rd and we;
  - go to WAIT.
- IDLE, any other case: outputs are combinational passthrough (`result_out` = `alu_result_MEMEX`), stall 0.
- WAIT:
  - `dbus_req`=1; addr/we/be/wdata are driven from the latched registers and held stable until ack;
  - stall 1;
  - on `dbus_ack`, capture the aligned load data and go to DONE.
- DONE:
  - stall 0;
  - `result_out` = captured load data (0 for a store), `rd_out` and `regfile_we_out` from the latched values;
  - the pipeline advances at the end of this cycle; go to IDLE.
- Load funct3 codes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. The selected byte or half is taken by addr[1:0] / addr[1], then sign- or zero-extended to 32 bits.
- Store funct3 codes: 000 SB, 001 SH, 010 SW.
  - `dbus_be`: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << {addr[1],1'b0}; SW = 4'b1111.
  - `dbus_wdata`: the byte replicated ×4 (SB), the half replicated ×2 (SH), or the full word (SW).
- Illegal funct3 for a memory op (011, 110, 111, or 010-class codes for stores above 010): no bus access, `regfile_we_out`=0, `result_out`=0, no stall.
- `invalid_MEMEX`=1 forces `regfile_we_out`=0 and suppresses any access.
- `dbus_ack` is ignored outside WAIT.
- Upstream inputs may change during WAIT; all access fields are latched, so this has no effect.

## Timing
- Reset values:
  - state IDLE;
  - `dbus_req`=0, `dbus_we`=0, `dbus_be`=0, `dbus_addr`=0, `dbus_wdata`=0;
  - `misaligned_MEMEX`=0;
  - latched rd/result/we registers = 0.
- Because IDLE outputs are combinational passthrough, `stall_MEMEX`, `rd_out`, `result_out` and `regfile_we_out` under reset track the inputs.
- Memory op with 0-wait bus (ack in the first WAIT cycle): stall for 2 cycles (IDLE, WAIT); the result is valid in the 3rd cycle (DONE).
- Each wait cycle before ack adds one stall cycle.
- Non-memory ops: 0 added cycles.
- Back-to-back memory ops: a new op is accepted in the IDLE cycle after DONE, leaving at least one bubble-free cycle between accesses.
- Reset during WAIT:
  - state returns to IDLE and `dbus_req` drops next edge;
  - the bus must tolerate an abandoned request;
  - no writeback is produced.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]≠0) produces no bus access and no stall;
  - `misaligned_MEMEX`=1 for that cycle and `regfile_we_out`=0.
- `MISALIGN_TRAP_EN` undefined:
  - low address bits are masked (half uses addr[1] only; word uses offset 0) and the access proceeds;
  - `misaligned_MEMEX` is tied 0.

## Structure
- `lsu_pkg` holds:
  - the FSM state enum (IDLE/WAIT/DONE);
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the byte-enable/wdata helper functions.
- Sub-module `lsu_load_align` is combinational: inputs rdata, offset, funct3; output is the extended 32-bit value.

## Test plan
- LB at address 0x103, bus returns 0x80AABBCC after 0 waits → `dbus_addr`=0x100, `dbus_be`=0, stall high for 2 cycles, `result_out`=0xFFFFFF80 with we=1 in the DONE cycle.
- SH of 0x1234ABCD at address 0x202 with ack after 3 waits → `dbus_be`=4'b1100, `dbus_wdata`=0xABCDABCD, req held stable for 4 cycles, stall for 5 cycles, `regfile_we_out`=0.
- LHU at 0x10, rdata=0x0000F00F; next an ALU op with result 0x55 → `result_out`=0x0000F00F, then 0x55 with no stall.
- `invalid_MEMEX`=1 on an LW → `dbus_req` never asserted, stall 0, `regfile_we_out`=0.
- LW at 0x06: with `MISALIGN_TRAP_EN`, `misaligned_MEMEX` pulses 1 and there is no req; without it, `dbus_addr`=0x04 and the load completes normally.
- `rst_n`=0 asserted in WAIT → `dbus_req`=0 and state IDLE next edge; a subsequent ack is ignored and no writeback occurs.
